// File: rtl/gpio_in_filter.sv
// Per-pin GPIO input conditioner: 2-flop synchronizer, N-cycle stability filter, sticky edge events, irq.
// Latency: pin -> filt_data in 1+Neff edges after sync1 capture, event +1, irq +1; no backpressure (free-running).
module gpio_in_filter #(
   parameter int IOWidth     = 36,
   parameter int FilterWidth = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [IOWidth-1:0]     pin_in,
   input  logic [IOWidth-1:0]     filter_en,
   input  logic [FilterWidth-1:0] filter_len,
   input  logic [IOWidth-1:0]     rise_en,
   input  logic [IOWidth-1:0]     fall_en,
   input  logic [IOWidth-1:0]     event_clr,
   output logic [IOWidth-1:0]     filt_data,
   output logic [IOWidth-1:0]     o_event,
   output logic                   irq
);

   logic [IOWidth-1:0]     r_sync1;
   logic [IOWidth-1:0]     r_sync2;
   logic [IOWidth-1:0]     r_filt;
   logic [IOWidth-1:0]     r_filt_q;
   logic [IOWidth-1:0]     r_event;
   logic                   r_irq;
   logic [FilterWidth-1:0] r_cnt      [IOWidth];

   logic [FilterWidth-1:0] w_term     [IOWidth];
   logic [FilterWidth-1:0] w_cnt_nxt  [IOWidth];
   logic [IOWidth-1:0]     w_filt_nxt;
   logic [IOWidth-1:0]     w_rise;
   logic [IOWidth-1:0]     w_fall;
   logic [IOWidth-1:0]     w_set;

   // w_term is Neff-1; >= keeps a shortened filter_len from stranding cnt past terminal
   always_comb begin
      for (int i = 0; i < IOWidth; i++) begin
         w_term[i]     = '0;
         w_cnt_nxt[i]  = '0;
         w_filt_nxt[i] = r_filt[i];
         if (filter_en[i] && (filter_len != '0)) begin
            w_term[i] = filter_len - FilterWidth'(1);
         end
         if (r_sync2[i] != r_filt[i]) begin
            if (r_cnt[i] >= w_term[i]) begin
               w_filt_nxt[i] = r_sync2[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + FilterWidth'(1);
            end
         end
      end
   end

   assign w_rise = r_filt & ~r_filt_q;
   assign w_fall = ~r_filt & r_filt_q;
   assign w_set  = (w_rise & rise_en) | (w_fall & fall_en);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_filt   <= '0;
         r_filt_q <= '0;
         r_event  <= '0;
         r_irq    <= 1'b0;
         for (int i = 0; i < IOWidth; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1  <= pin_in;
         r_sync2  <= r_sync1;
         r_filt   <= w_filt_nxt;
         r_filt_q <= r_filt;
         // set wins over a coincident clear
         r_event  <= w_set | (r_event & ~event_clr);
         r_irq    <= |r_event;
         for (int i = 0; i < IOWidth; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

   assign filt_data = r_filt;
   assign o_event   = r_event;
   assign irq       = r_irq;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed and random stimulus for gpio_in_filter, checked against a run-length model of the filter.
module tb_gpio_in_filter;

   localparam int W  = 36;
   localparam int FW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  pin_in, filter_en, rise_en, fall_en, event_clr;
   logic [FW-1:0] filter_len;
   logic [W-1:0]  filt_data, o_event;
   logic          irq;

   int checks = 0;
   int errors = 0;

   // model: run[i] = consecutive earlier cycles in which sync2 disagreed with the filtered level
   logic [W-1:0] m_s1, m_s2, m_filt, m_fq, m_evt;
   logic         m_irq;
   int           m_run [W];

   gpio_in_filter #(.IOWidth(W), .FilterWidth(FW)) dut (
      .clk(clk), .reset(reset), .pin_in(pin_in), .filter_en(filter_en),
      .filter_len(filter_len), .rise_en(rise_en), .fall_en(fall_en),
      .event_clr(event_clr), .filt_data(filt_data), .o_event(o_event), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_vec();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[W-1:0];
   endfunction

   // advance one clock: model computes from pre-edge inputs, compare #1 after the edge
   task automatic step();
      logic [W-1:0] n_filt, n_evt, rise, fall;
      int           n_run [W];
      int           neff;
      n_filt = m_filt;
      for (int i = 0; i < W; i++) begin
         neff = (!filter_en[i] || filter_len == 0) ? 1 : int'(filter_len);
         if (m_s2[i] == m_filt[i]) n_run[i] = 0;
         else if (m_run[i] + 1 >= neff) begin
            n_filt[i] = m_s2[i];
            n_run[i]  = 0;
         end else n_run[i] = m_run[i] + 1;
      end
      rise  = m_filt & ~m_fq;
      fall  = m_fq & ~m_filt;
      n_evt = (m_evt & ~event_clr) | (rise & rise_en) | (fall & fall_en);
      @(posedge clk);
      #1;
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_filt = '0; m_fq = '0; m_evt = '0; m_irq = 1'b0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
      end else begin
         m_irq  = |m_evt;
         m_fq   = m_filt;
         m_s2   = m_s1;
         m_s1   = pin_in;
         m_filt = n_filt;
         m_evt  = n_evt;
         for (int i = 0; i < W; i++) m_run[i] = n_run[i];
      end
      check("model_filt", filt_data, m_filt);
      check("model_event", o_event, m_evt);
      check1("model_irq", irq, m_irq);
   endtask

   initial begin
      logic seen;
      reset = 1'b1; pin_in = '0; filter_en = '0; filter_len = '0;
      rise_en = '0; fall_en = '0; event_clr = '0;
      m_s1 = 'x; m_s2 = 'x; m_filt = 'x; m_fq = 'x; m_evt = 'x; m_irq = 1'bx;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      repeat (3) step();
      check("reset_filt", filt_data, '0);
      check("reset_event", o_event, '0);
      check1("reset_irq", irq, 1'b0);

      // bypass latency and event/irq chain on pin 0
      reset = 1'b0; rise_en = '1; fall_en = '1;
      repeat (2) step();
      pin_in[0] = 1'b1;
      step(); step();
      check1("bypass_k1_filt", filt_data[0], 1'b0);
      step();
      check1("bypass_k2_filt", filt_data[0], 1'b1);
      check1("bypass_k2_event", o_event[0], 1'b0);
      step();
      check1("bypass_event", o_event[0], 1'b1);
      check1("bypass_irq_early", irq, 1'b0);
      step();
      check1("bypass_irq", irq, 1'b1);
      event_clr = '1; step(); event_clr = '0;
      check("clr_all_event", o_event, '0);
      check1("clr_all_irq_lag", irq, 1'b1);
      step();
      check1("clr_all_irq", irq, 1'b0);

      // glitch rejection with filter_len=4 on pin 5
      filter_len = 8'd4; filter_en = '1;
      pin_in[5] = 1'b1; repeat (3) step(); pin_in[5] = 1'b0;
      for (int s = 0; s < 8; s++) begin
         step();
         check1("glitch3_filt", filt_data[5], 1'b0);
      end
      check1("glitch3_event", o_event[5], 1'b0);
      pin_in[5] = 1'b1; repeat (4) step(); pin_in[5] = 1'b0;
      seen = 1'b0;
      for (int s = 0; s < 10; s++) begin
         step();
         seen |= filt_data[5];
      end
      check1("pulse4_passes", seen, 1'b1);
      event_clr = '1; step(); event_clr = '0; step();

      // event clear, then clear coincident with a fall on pin 3
      pin_in[3] = 1'b1; repeat (8) step();
      check1("pin3_rise_event", o_event[3], 1'b1);
      event_clr[3] = 1'b1; step(); event_clr = '0;
      check1("pin3_cleared", o_event[3], 1'b0);
      step();
      check1("pin3_irq_cleared", irq, 1'b0);
      pin_in[3] = 1'b0;
      for (int s = 0; s < 20; s++) begin
         step();
         if (filt_data[3] == 1'b0) break;
      end
      check1("pin3_fall_bound", filt_data[3], 1'b0);
      event_clr[3] = 1'b1; step(); event_clr = '0;
      check1("set_wins_clear", o_event[3], 1'b1);
      event_clr = '1; step(); event_clr = '0;

      // shorten filter_len while pin 7 is mid-count
      filter_len = 8'd10;
      pin_in[7] = 1'b1; repeat (2) step();
      repeat (7) step();
      check1("lenchg_hold", filt_data[7], 1'b0);
      filter_len = 8'd3; step();
      check1("lenchg_update", filt_data[7], 1'b1);

      // reset over a full set of events, then pin 9 high through release
      filter_en = '0; repeat (4) step();
      pin_in = ~pin_in; repeat (4) step();
      check("all_events_set", o_event, '1);
      reset = 1'b1; step();
      check("midop_reset_filt", filt_data, '0);
      check("midop_reset_event", o_event, '0);
      check1("midop_reset_irq", irq, 1'b0);
      pin_in = '0; pin_in[9] = 1'b1; step();
      reset = 1'b0;
      for (int s = 1; s <= 4; s++) begin
         step();
         check1("release_event9", o_event[9], s == 4);
      end

      // random soak
      for (int s = 0; s < 600; s++) begin
         reset      = ($urandom_range(0, 79) == 0);
         pin_in     = pin_in ^ (rnd_vec() & rnd_vec() & rnd_vec());
         if ($urandom_range(0, 15) == 0) filter_en = rnd_vec();
         if ($urandom_range(0, 15) == 0) filter_len = FW'($urandom_range(0, 5));
         if ($urandom_range(0, 31) == 0) rise_en = rnd_vec();
         if ($urandom_range(0, 31) == 0) fall_en = rnd_vec();
         event_clr  = ($urandom_range(0, 3) == 0) ? rnd_vec() : '0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
